// File: rtl/cache_control_l2.sv
`timescale 1ns/1ps
// cache_control_l2
// Sequencing controller for the two-way L2 cache datapath. It decides between
// a hit, a clean-miss fill and a dirty-miss write-back followed by a fill. It
// drives the datapath selects and the physical-memory strobes, and keeps
// saturating hit/miss/write-back counters.
//
// In WRITEBACK and FILL the memory strobes and selects depend only on the
// state, so they are registered together with the state. The L1 response
// (mem_resp, real_mem_resp) depends on the live request and tag match while
// in CHECK, so it is decoded combinationally. It is gated by reset so that
// every output reads 0 while reset is asserted.
module cache_control_l2 #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic                 hit,
  input  logic                 dirty,
  input  logic                 pmem_resp,
  input  logic                 counter_clear,
  output logic                 mem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic                 sel_way_mux,
  output logic                 pmem_mux_sel,
  output logic                 real_mem_resp,
  output logic                 prefetch,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
);

  typedef enum logic [1:0] {
    CHECK     = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t state_reg;
  logic   miss_pending_reg;
  logic   pmem_read_reg;
  logic   pmem_write_reg;
  logic   sel_way_mux_reg;
  logic   pmem_mux_sel_reg;

  logic   req;
  logic   in_check;
  logic   hit_event;
  logic   miss_event;
  logic   wb_event;
  logic [2:0] cnt_event;

  // A simultaneous read and write is treated as a write. Either one is a request.
  assign req      = mem_read | mem_write;
  assign in_check = (state_reg == CHECK);

  // Counter events. The hit that completes a previously missed request is
  // not counted as a hit.
  assign hit_event  = in_check & req & hit & ~miss_pending_reg;
  assign miss_event = in_check & req & ~hit;
  assign wb_event   = (state_reg == WRITEBACK) & pmem_resp;
  assign cnt_event  = {wb_event, miss_event, hit_event};

  // Mealy L1 response in CHECK, forced low while reset is held.
  assign mem_resp      = reset & in_check & req & hit;
  assign real_mem_resp = reset & in_check & req & hit & mem_read & ~mem_write;

  assign pmem_read    = pmem_read_reg;
  assign pmem_write   = pmem_write_reg;
  assign sel_way_mux  = sel_way_mux_reg;
  assign pmem_mux_sel = pmem_mux_sel_reg;
  assign prefetch     = 1'b0;

  // State sequencing with registered Moore strobes for the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= CHECK;
      miss_pending_reg <= 1'b0;
      pmem_read_reg    <= 1'b0;
      pmem_write_reg   <= 1'b0;
      sel_way_mux_reg  <= 1'b0;
      pmem_mux_sel_reg <= 1'b0;
    end else begin
      case (state_reg)
        CHECK: begin
          if (req && !hit) begin
            // Miss: evict first if the victim is dirty, otherwise fetch directly.
            miss_pending_reg <= 1'b1;
            sel_way_mux_reg  <= 1'b1;
            if (dirty) begin
              state_reg        <= WRITEBACK;
              pmem_write_reg   <= 1'b1;
              pmem_read_reg    <= 1'b0;
              pmem_mux_sel_reg <= 1'b1;
            end else begin
              state_reg        <= FILL;
              pmem_write_reg   <= 1'b0;
              pmem_read_reg    <= 1'b1;
              pmem_mux_sel_reg <= 1'b0;
            end
          end else begin
            // A completing hit or an idle cycle clears any outstanding miss.
            state_reg        <= CHECK;
            miss_pending_reg <= 1'b0;
            pmem_read_reg    <= 1'b0;
            pmem_write_reg   <= 1'b0;
            sel_way_mux_reg  <= 1'b0;
            pmem_mux_sel_reg <= 1'b0;
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            // Victim is written back; now fetch the requested line.
            state_reg        <= FILL;
            pmem_write_reg   <= 1'b0;
            pmem_read_reg    <= 1'b1;
            pmem_mux_sel_reg <= 1'b0;
            sel_way_mux_reg  <= 1'b1;
          end
        end
        FILL: begin
          if (pmem_resp) begin
            // Line installed in the victim way; the retry in CHECK will hit.
            state_reg        <= CHECK;
            pmem_read_reg    <= 1'b0;
            pmem_write_reg   <= 1'b0;
            sel_way_mux_reg  <= 1'b0;
            pmem_mux_sel_reg <= 1'b0;
          end
        end
        default: begin
          state_reg        <= CHECK;
          miss_pending_reg <= 1'b0;
          pmem_read_reg    <= 1'b0;
          pmem_write_reg   <= 1'b0;
          sel_way_mux_reg  <= 1'b0;
          pmem_mux_sel_reg <= 1'b0;
        end
      endcase
    end
  end

  // Three identical saturating counters: index 0 hits, 1 misses, 2 write-backs.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cnt
      logic [CNT_WIDTH-1:0] count_reg;

      // Clear has priority over a same-cycle increment; the count holds at all-ones.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          count_reg <= '0;
        end else if (counter_clear) begin
          count_reg <= '0;
        end else if (cnt_event[gi] && (count_reg != '1)) begin
          count_reg <= count_reg + CNT_ONE;
        end
      end
    end
  endgenerate

  assign hit_count  = g_cnt[0].count_reg;
  assign miss_count = g_cnt[1].count_reg;
  assign wb_count   = g_cnt[2].count_reg;

endmodule

// File: doc/cache_control_l2.md
# cache_control_l2

Sequencing controller for the two-way L2 cache datapath (`cache_datapath_l2`). It sits between the L1-facing request port and the physical-memory port. It decides hit, clean-miss fill and dirty-miss write-back-then-fill, and drives the datapath's way-select, address-select, LRU-update and memory strobes. It also keeps saturating hit/miss/write-back counters for performance analysis.

## Interface
- `CNT_WIDTH`, default 16: width of each performance counter.
- `clk` input 1: system clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low (asserted when 0); forces state to CHECK and clears counters and `miss_pending`.
- `mem_read` input 1: L1 read request; held until `mem_resp`.
- `mem_write` input 1: L1 write request; held until `mem_resp`.
- `hit` input 1: datapath tag-match for the current `mem_address`.
- `dirty` input 1: dirty bit of the datapath's LRU victim way.
- `pmem_resp` input 1: physical-memory completion strobe.
- `counter_clear` input 1: synchronous clear of all counters.
- `mem_resp` output 1: L1 request complete.
- `pmem_read` output 1: physical-memory read strobe; also routed to the datapath.
- `pmem_write` output 1: physical-memory write strobe.
- `sel_way_mux` output 1: 0 selects the hit way, 1 selects the LRU victim way.
- `pmem_mux_sel` output 1: 0 drives `mem_address` to pmem, 1 drives the victim's tag address.
- `real_mem_resp` output 1: LRU update on a read hit.
- `prefetch` output 1: tied to 0 in this revision.
- `hit_count`, `miss_count`, `wb_count` output CNT_WIDTH: saturating event counters.

## Operation
- States: CHECK (reset/idle), WRITEBACK, FILL. Two-bit state register.
- CHECK with no request: every strobe is 0 and the state stays CHECK.
- CHECK, request with `hit`=1:
  - `mem_resp`=1 and `sel_way_mux`=0 in the same cycle.
  - `real_mem_resp`=`mem_read & !mem_write`.
  - A write hit is committed by the datapath itself.
  - The state stays CHECK.
- CHECK, request with `hit`=0:
  - No `mem_resp`. Set `miss_pending`; `miss_count`+1.
  - Next state is WRITEBACK if `dirty`=1, else FILL.
- WRITEBACK:
  - `pmem_write`=1, `pmem_mux_sel`=1, `sel_way_mux`=1.
  - On `pmem_resp`: `wb_count`+1 and go to FILL. Otherwise hold.
- FILL:
  - `pmem_read`=1, `pmem_mux_sel`=0, `sel_way_mux`=1.
  - On `pmem_resp` the datapath installs the line in the victim way and the state goes to CHECK. Otherwise hold.
- Back in CHECK after a miss, the request now hits and completes normally.
  - `hit_count` increments only on hits with `miss_pending`=0.
  - The completing hit clears `miss_pending`.
- `mem_read` and `mem_write` both high is illegal. It is treated as a write (`real_mem_resp`=0).
- Request dropped while in WRITEBACK or FILL: the memory transaction still completes, then the state returns to CHECK. `miss_pending` clears on re-entry to CHECK with no request.
- Counters saturate at 2^CNT_WIDTH−1. `counter_clear` has priority over any same-cycle increment.
- `prefetch`=0 at all times.

## Timing
- Reset (`reset`=0): state CHECK, counters 0, `miss_pending` 0. Every output is 0, including combinational `mem_resp` and `real_mem_resp`, regardless of inputs.
- Reset asserted mid-WRITEBACK or mid-FILL: strobes drop immediately (asynchronous). The in-flight memory transaction is abandoned.
- Outputs are Moore in WRITEBACK and FILL. In CHECK they are Mealy on `mem_read`/`mem_write`/`hit`.
- Hit latency: `mem_resp` in the first cycle the request is present in CHECK.
- Clean-miss latency:
  - Request at cycle 0; FILL at cycle 1 with `pmem_read` high.
  - `pmem_resp` arrives at cycle 1+L (L≥0).
  - CHECK hit with `mem_resp` at cycle 2+L.
- Dirty-miss latency:
  - WRITEBACK at cycle 1; `pmem_resp` at cycle 1+Lw.
  - FILL at cycle 2+Lw; `pmem_resp` at cycle 2+Lw+Lr.
  - `mem_resp` at cycle 3+Lw+Lr.
- `pmem_read` and `pmem_write` are never high together.
- `pmem_resp` seen in CHECK is ignored.

## Test plan
- Read hit: preload a line; `mem_read`=1, `hit`=1 → `mem_resp`=1 and `real_mem_resp`=1 in the same cycle; `hit_count` 0→1; no pmem strobe.
- Clean read miss, L=3: `hit`=0, `dirty`=0 → `pmem_read` high for cycles 1–4, `pmem_mux_sel`=0, `sel_way_mux`=1; `mem_resp` at cycle 5; `miss_count`=1, `hit_count`=0.
- Dirty write miss, Lw=2 and Lr=2: `pmem_write` with `pmem_mux_sel`=1 for cycles 1–3, then `pmem_read` for cycles 4–6; `mem_resp` at cycle 7; `wb_count`=1.
- Reset at cycle 2 of FILL → `pmem_read` falls in the same cycle; after release the state is CHECK and all counters are 0.
- Request dropped in FILL → the fill still completes on `pmem_resp`, no `mem_resp` is issued, and the controller returns to CHECK idle.
- CNT_WIDTH=4 with 20 hits → `hit_count` holds at 15; `counter_clear` asserted in the same cycle as a hit → `hit_count`=0.
